// File: rtl/axi_write_slave_if.sv
// AXI3 write-channel bundle (AW, W, B) shared by the write master and the write slave.
interface axi_write_slave_if #(
    parameter int unsigned buswidth = 32
);
    logic [3:0]            AWID;
    logic [31:0]           AWADDR;
    logic [3:0]            AWLEN;
    logic [2:0]            AWSIZE;
    logic [1:0]            AWBURST;
    logic [1:0]            AWLOCK;
    logic [3:0]            AWCACHE;
    logic [2:0]            AWPROT;
    logic                  AWVALID;
    logic                  AWREADY;
    logic [3:0]            WID;
    logic [buswidth-1:0]   WDATA;
    logic [buswidth/8-1:0] WSTRB;
    logic                  WLAST;
    logic                  WVALID;
    logic                  WREADY;
    logic [3:0]            BID;
    logic [1:0]            BRESP;
    logic                  BVALID;
    logic                  BREADY;

    modport master (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWVALID,
        output WID, WDATA, WSTRB, WLAST, WVALID,
        output BREADY,
        input  AWREADY, WREADY, BID, BRESP, BVALID
    );

    modport slave (
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWVALID,
        input  WID, WDATA, WSTRB, WLAST, WVALID,
        input  BREADY,
        output AWREADY, WREADY, BID, BRESP, BVALID
    );
endinterface

// File: rtl/axi_write_slave.sv
// AXI3 write slave: one burst at a time into a byte-strobed word memory, one B response per
// burst, plus a combinational debug read port.
module axi_write_slave #(
    parameter int unsigned buswidth = 32,
    parameter int unsigned memdepth = 64
) (
    input  logic                        ACLK,
    input  logic                        ARESETn,
    axi_write_slave_if.slave            bus,
    input  logic [$clog2(memdepth)-1:0] rd_addr,
    output logic [buswidth-1:0]         rd_data
);
    localparam int unsigned lanes    = buswidth / 8;
    localparam int unsigned lanebits = $clog2(lanes);
    localparam int unsigned aw       = $clog2(memdepth);

    typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

    state_t              state, next_state;
    logic [3:0]          id_q, len_q, count_q;
    logic [31:0]         addr_q;
    logic [2:0]          size_q;
    logic [1:0]          burst_q;
    logic                err_q, drop_q;
    logic                awready_q, wready_q, bvalid_q;
    logic [buswidth-1:0] mem [memdepth];

    logic        aw_hs, w_hs, b_hs, last_beat, aw_bad, in_range;
    logic [31:0] step, bound, word_idx, next_addr;

    assign aw_hs     = bus.AWVALID && awready_q;
    assign w_hs      = bus.WVALID && wready_q;
    assign b_hs      = bvalid_q && bus.BREADY;
    assign last_beat = (count_q == len_q);
    assign step      = 32'd1 << size_q;
    assign bound     = ({28'd0, len_q} + 32'd1) << size_q;
    assign word_idx  = addr_q >> lanebits;
    assign in_range  = (word_idx < memdepth);

    assign bus.AWREADY = awready_q;
    assign bus.WREADY  = wready_q;
    assign bus.BVALID  = bvalid_q;
    assign bus.BID     = id_q;
    assign bus.BRESP   = {err_q, 1'b0};
    assign rd_data     = mem[rd_addr];

    // Burst-level errors that make the whole burst a no-op on memory.
    always_comb begin
        aw_bad = 1'b0;
        if (bus.AWBURST == 2'b11)
            aw_bad = 1'b1;
        if ({29'd0, bus.AWSIZE} > lanebits)
            aw_bad = 1'b1;
        if (bus.AWBURST == 2'b10 && !(bus.AWLEN inside {4'd1, 4'd3, 4'd7, 4'd15}))
            aw_bad = 1'b1;
    end

    always_comb begin
        next_addr = addr_q;
        unique case (burst_q)
            2'b01:   next_addr = addr_q + step;
            2'b10:   next_addr = (addr_q & ~(bound - 32'd1)) | ((addr_q + step) & (bound - 32'd1));
            default: next_addr = addr_q;
        endcase
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (aw_hs) next_state = DATA;
            DATA:    if (w_hs && last_beat) next_state = RESP;
            RESP:    if (b_hs) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Handshake outputs are registered copies of the state being entered.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state     <= IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
        end else begin
            state     <= next_state;
            awready_q <= (next_state == IDLE);
            wready_q  <= (next_state == DATA);
            bvalid_q  <= (next_state == RESP);
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            size_q  <= '0;
            burst_q <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else if (aw_hs) begin
            id_q    <= bus.AWID;
            addr_q  <= bus.AWADDR;
            len_q   <= bus.AWLEN;
            size_q  <= bus.AWSIZE;
            burst_q <= bus.AWBURST;
            count_q <= '0;
            err_q   <= aw_bad;
            drop_q  <= aw_bad;
        end else if (w_hs) begin
            addr_q  <= next_addr;
            count_q <= count_q + 4'd1;
            if (!in_range || bus.WID != id_q || bus.WLAST != last_beat)
                err_q <= 1'b1;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            for (int unsigned i = 0; i < memdepth; i++)
                mem[i] <= '0;
        end else if (w_hs && !drop_q && in_range) begin
            for (int unsigned b = 0; b < lanes; b++)
                if (bus.WSTRB[b])
                    mem[word_idx[aw-1:0]][8*b +: 8] <= bus.WDATA[8*b +: 8];
        end
    end
endmodule
